aes_ctr_stream: RTL and testbench
=================================

Name: aes_ctr_stream

Overview:
Streaming AES-128 counter-mode engine. It is the parametrised successor of the single-shot start/done encrypt top.
- Accepts a session configuration: key, nonce/IV and block count.
- Prefetches keystream blocks from an iterative AES cipher core into a small buffer.
- XORs each keystream block with input data under valid/ready handshakes on both sides.
- Sits between the DMA/stream fabric and the crypto subsystem; generalises counter width, session length and prefetch depth.

Parameters:
- CTR_WIDTH, 32: low bits of the 128-bit counter block that increment; upper 128-CTR_WIDTH bits are fixed nonce. Legal range 8..64.
- LEN_WIDTH, 16: width of the session block-count field.
- KS_DEPTH, 2: keystream prefetch buffer entries. Power of two, 1..8.

Ports:
- clk, input, 1: clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high; clears all state.
- cfg_valid, input, 1: session configuration present.
- cfg_ready, output, 1: engine idle, configuration can be accepted.
- cfg_key, input, 128: AES-128 key.
- cfg_nonce, input, 128: initial counter block; low CTR_WIDTH bits are the start counter.
- cfg_blocks, input, LEN_WIDTH: number of 128-bit blocks in the session.
- in_valid, input, 1: input data block valid.
- in_ready, output, 1: input block accepted this cycle when in_valid is also high.
- in_data, input, 128: plaintext or ciphertext block.
- out_valid, output, 1: output block valid.
- out_ready, input, 1: downstream accepts the output block.
- out_data, output, 128: in_data XOR keystream.
- out_last, output, 1: qualifies the final block of the session.
- done, output, 1: one-cycle pulse when the last block is accepted downstream.
- busy, output, 1: a session is active.
- err, output, 1: one-cycle pulse on counter wrap; present only with the optional feature, otherwise tied to 0.

Behaviour:
- Reset values:
  - cfg_ready=1; in_ready=0; out_valid=0; out_data=0; out_last=0; done=0; busy=0; err=0.
  - Keystream buffer emptied; internal counters zeroed; cipher core reset.
  - Reset mid-session abandons the session; no done pulse is issued.
- Configuration:
  - Load occurs on cfg_valid && cfg_ready.
  - Key, nonce and block count are registered; generate-remaining and output-remaining counters are set to cfg_blocks; busy=1 from the next cycle.
  - cfg_valid while busy is ignored, since cfg_ready=0.
- cfg_blocks=0: load accepted; done pulses in the cycle after the load; busy stays 0; no output blocks.
- Generator FSM, states G_IDLE, G_START, G_WAIT:
  - G_IDLE -> G_START when busy && gen_remaining>0 && buffer not full.
  - G_START: drive a one-cycle start to the core with the current counter block -> G_WAIT.
  - G_WAIT: on core done, push block_out into the buffer; increment the counter field modulo 2^CTR_WIDTH, leaving upper bits unchanged; decrement gen_remaining -> G_IDLE.
  - The core's latency is not hard-coded; the FSM waits for done.
- Data path:
  - in_ready = busy && buffer non-empty && (!out_valid || out_ready).
  - On in_valid && in_ready: pop the buffer head; register out_data = in_data ^ head; out_valid=1; out_last=1 if out_remaining==1; decrement out_remaining.
  - Input-to-output latency is 1 cycle.
- Output hold: out_valid, out_data and out_last stay stable while out_valid && !out_ready.
- Session end: on out_valid && out_ready && out_last, done pulses for 1 cycle, busy=0 and cfg_ready=1 in the same cycle that done is high.
- Simultaneous buffer push and pop in one cycle: occupancy is unchanged, with no loss or duplication.
- Buffer full: the generator stalls in G_IDLE.
- Buffer empty: in_ready=0.
- Counter wrap: all-ones -> zero; behaviour depends on the optional feature.

Optional Feature:
CTR_WRAP_CHECK_EN
- Defined: when a generated block leaves the counter field at all-ones and gen_remaining>1, err pulses for 1 cycle. The session then aborts:
  - the buffer is flushed;
  - busy=0, cfg_ready=1;
  - no done pulse;
  - any pending out_valid is dropped.
- Not defined: the counter wraps silently modulo 2^CTR_WIDTH; err is constant 0.

Decomposition:
- Package aes_ctr_pkg holds:
  - the AES_BLOCK_W=128 and AES_KEY_W=128 constants;
  - the generator FSM state enum;
  - the counter-increment function (masked add on the low CTR_WIDTH bits).
- Sub-module aes_cipher_core is the team's iterative AES-128 encrypt core, instantiated once.
  - Interface: clk, reset, start, key, block_in, block_out, done.
- The keystream buffer is inline (circular array with pointers), not a separate module.

Test Plan:
- FIPS-197 vector. Stimulus: CTR_WIDTH=32, key 000102030405060708090a0b0c0d0e0f, nonce 00112233445566778899aabbccddeeff, cfg_blocks=1, in_data=0. Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1, done pulses once.
- Round-trip. Stimulus: same configuration, cfg_blocks=2, block 0 in_data=69c4e0d86a7b0430d8cdb78070b4c55a. Required: block 0 out_data=0; the core received counter blocks ...ccddeeff then ...ccddef00 in that order.
- Backpressure. Stimulus: cfg_blocks=4, in_valid held high, out_ready low for 20 cycles. Required: out_data stable; in_ready=0 while out_valid && !out_ready; exactly 4 distinct outputs after release; one done pulse.
- Wrap. Stimulus: CTR_WIDTH=8, nonce low byte ff, cfg_blocks=2. Required without the macro: second counter block low byte 00, upper 120 bits unchanged. Required with the macro: err pulses, no done, cfg_ready=1.
- Edge cases:
  - cfg_blocks=0: done pulses the cycle after load, out_valid stays 0.
  - Reset asserted during block 2 of 4: all outputs at reset values next cycle; a new session then runs correctly.

Source files
------------

// File: rtl/aes_ctr_pkg.sv
// aes_ctr_pkg: shared widths, generator states and the
// counter-field increment used by the CTR stream engine.
package aes_ctr_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 128;

  typedef enum logic [1:0] {
    G_IDLE,
    G_START,
    G_WAIT
  } gen_state_t;

  // Increment only the low w bits; upper nonce bits never see the carry
  function automatic logic [AES_BLOCK_W-1:0] ctr_inc(
    input logic [AES_BLOCK_W-1:0] blk,
    input int                     w
  );
    logic [AES_BLOCK_W-1:0] mask;
    mask = (w >= AES_BLOCK_W) ? '1 :
           ((AES_BLOCK_W'(1) << w) - AES_BLOCK_W'(1));
    return (blk & ~mask) |
           ((blk + AES_BLOCK_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES-128 encrypt, one round per
// cycle with on-the-fly key expansion; done pulses with result.
module aes_cipher_core
  import aes_ctr_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AES_KEY_W-1:0]   key,
  input  logic [AES_BLOCK_W-1:0] block_in,
  output logic [AES_BLOCK_W-1:0] block_out,
  output logic                   done
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_next(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]),
          sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(
    input logic [127:0] s,
    input logic [127:0] k,
    input logic         last
  );
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        t[4*c+j] = b[4*((c+j)%4)+j];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last)
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        r[127-32*c -: 32] = {
          xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
          a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
          a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
          xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r ^ k;
  endfunction

  logic [127:0] st, rk, nk, nst;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic         run;

  always_comb begin
    nk  = key_next(rk, rcon);
    nst = aes_round(st, nk, rnd == 4'd10);
  end

  assign block_out = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= '0;
      rk   <= '0;
      rnd  <= '0;
      rcon <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        st   <= block_in ^ key;
        rk   <= key;
        rnd  <= 4'd1;
        rcon <= 8'h01;
        run  <= 1'b1;
      end else if (run) begin
        st   <= nst;
        rk   <= nk;
        rcon <= xtime(rcon);
        rnd  <= rnd + 4'd1;
        if (rnd == 4'd10) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: AES-128 CTR engine with keystream prefetch.
// Define CTR_WRAP_CHECK_EN to abort sessions on counter wrap.
module aes_ctr_stream
  import aes_ctr_pkg::*;
#(
  parameter int CTR_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  parameter int KS_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [AES_KEY_W-1:0]   cfg_key,
  input  logic [AES_BLOCK_W-1:0] cfg_nonce,
  input  logic [LEN_WIDTH-1:0]   cfg_blocks,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   out_last,
  output logic                   done,
  output logic                   busy,
  output logic                   err
);

  localparam int PW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int CW = $clog2(KS_DEPTH + 1);

  logic [AES_KEY_W-1:0]   key_q;
  logic [AES_BLOCK_W-1:0] ctr_q;
  logic [AES_BLOCK_W-1:0] core_out;
  logic [AES_BLOCK_W-1:0] ks [KS_DEPTH];
  logic [LEN_WIDTH-1:0]   gen_rem, out_rem;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  gen_state_t             gstate;
  logic                   core_start, core_done;
  logic                   push, pop, full, empty;
  logic                   wrap_abort;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(KS_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = count == CW'(KS_DEPTH);
  assign empty     = count == '0;
  assign cfg_ready = !busy;
  assign in_ready  = busy && !empty && (!out_valid || out_ready);
  assign pop       = in_valid && in_ready;
  assign push      = (gstate == G_WAIT) && core_done;

`ifdef CTR_WRAP_CHECK_EN
  // The block just made used the last counter value, yet more are owed
  assign wrap_abort = push && (&ctr_q[CTR_WIDTH-1:0]) &&
                      (gen_rem > LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= wrap_abort;
  end
`else
  assign wrap_abort = 1'b0;
  assign err        = 1'b0;
`endif

  aes_cipher_core u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .key       (key_q),
    .block_in  (ctr_q),
    .block_out (core_out),
    .done      (core_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q      <= '0;
      ctr_q      <= '0;
      gen_rem    <= '0;
      out_rem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      gstate     <= G_IDLE;
      core_start <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done       <= 1'b0;
      core_start <= 1'b0;

      if (cfg_valid && cfg_ready) begin
        key_q   <= cfg_key;
        ctr_q   <= cfg_nonce;
        gen_rem <= cfg_blocks;
        out_rem <= cfg_blocks;
        busy    <= cfg_blocks != '0;
        done    <= cfg_blocks == '0;
      end

      unique case (gstate)
        G_IDLE: begin
          if (busy && gen_rem != '0 && !full) begin
            gstate     <= G_START;
            core_start <= 1'b1;
          end
        end
        G_START: gstate <= G_WAIT;
        G_WAIT: begin
          if (core_done) begin
            ks[wr_ptr] <= core_out;
            wr_ptr     <= ptr_inc(wr_ptr);
            ctr_q      <= ctr_inc(ctr_q, CTR_WIDTH);
            gen_rem    <= gen_rem - LEN_WIDTH'(1);
            gstate     <= G_IDLE;
          end
        end
        default: gstate <= G_IDLE;
      endcase

      if (pop) begin
        out_data  <= in_data ^ ks[rd_ptr];
        out_valid <= 1'b1;
        out_last  <= out_rem == LEN_WIDTH'(1);
        out_rem   <= out_rem - LEN_WIDTH'(1);
        rd_ptr    <= ptr_inc(rd_ptr);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (out_valid && out_ready && out_last) begin
        done <= 1'b1;
        busy <= 1'b0;
      end

      count <= count + CW'(push) - CW'(pop);

      if (wrap_abort) begin
        busy      <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        gstate    <= G_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb_aes_ctr_stream: directed vectors for the CTR stream engine,
// one 32-bit-counter instance and one 8-bit-counter instance.
module tb_aes_ctr_stream;

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NON  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] NON1 = 128'h00112233445566778899aabbccddef00;
  localparam logic [127:0] NON3 = 128'h00112233445566778899aabbccddef02;
  localparam logic [127:0] NONW = 128'h00112233445566778899aabbccddee00;
  localparam logic [127:0] FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sel = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_nonce = '0;
  logic [127:0] in_data = '0;
  logic [15:0]  cfg_blocks = '0;
  logic         cv0, cv1;
  logic         cr [2];
  logic         ir [2];
  logic         ov [2];
  logic         ol [2];
  logic         dn [2];
  logic         by [2];
  logic         er [2];
  logic [127:0] od [2];

  int           n_pass = 0;
  int           n_chk = 0;
  int           ndone = 0;
  int           nerr = 0;
  logic [127:0] blk_log [$];
  logic [127:0] din [8];
  logic [127:0] dout [8];
  logic [127:0] keep [4];
  logic         dlast [8];

  assign cv0 = cfg_valid & ~sel;
  assign cv1 = cfg_valid & sel;

  always #5 clk = ~clk;

  aes_ctr_stream #(.CTR_WIDTH(32)) d32 (
    .clk(clk), .reset(reset),
    .cfg_valid(cv0), .cfg_ready(cr[0]),
    .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
    .cfg_blocks(cfg_blocks),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_last(ol[0]),
    .done(dn[0]), .busy(by[0]), .err(er[0])
  );

  aes_ctr_stream #(.CTR_WIDTH(8)) d8 (
    .clk(clk), .reset(reset),
    .cfg_valid(cv1), .cfg_ready(cr[1]),
    .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
    .cfg_blocks(cfg_blocks),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_last(ol[1]),
    .done(dn[1]), .busy(by[1]), .err(er[1])
  );

  always @(negedge clk) begin
    if (dn[sel]) ndone++;
    if (er[sel]) nerr++;
    if (sel ? d8.u_core.start : d32.u_core.start)
      blk_log.push_back(sel ? d8.u_core.block_in : d32.u_core.block_in);
  end

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] ctl(input int s);
    return {cr[s], ir[s], ov[s], ol[s], dn[s], by[s], er[s]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ndone = 0;
    nerr = 0;
    blk_log.delete();
  endtask

  task automatic configure(input logic [127:0] n, input logic [15:0] b);
    check("cfg_ready", 128'(cr[sel]), 128'd1);
    cfg_key = KEY;
    cfg_nonce = n;
    cfg_blocks = b;
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic stream(input int n, input int lim, input int stall);
    int ni, no;
    logic seen, bad;
    logic [127:0] held;
    ni = 0; no = 0; seen = 0; bad = 0; held = '0;
    for (int t = 0; t < 3000 && no < lim; t++) begin
      in_valid = ni < n;
      in_data = (ni < n) ? din[ni] : '0;
      out_ready = t >= stall;
      @(negedge clk);
      if (ov[sel] && !out_ready) begin
        if (!seen) held = od[sel];
        seen = 1'b1;
        if (ir[sel] || od[sel] !== held) bad = 1'b1;
      end
      if (ov[sel] && out_ready) begin
        dout[no] = od[sel];
        dlast[no] = ol[sel];
        no++;
      end
      if (in_valid && ir[sel]) ni++;
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_count", 128'(no), 128'(lim));
    if (stall > 0) begin
      check("bp_held_seen", 128'(seen), 128'd1);
      check("bp_hold_stable", 128'(bad), 128'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dup;
    logic zov;
    repeat (3) cyc();
    check("rst_ctl", 128'(ctl(0)), 128'h40);
    check("rst_data", od[0], '0);
    check("rst_ctl8", 128'(ctl(1)), 128'h40);
    reset = 1'b0;
    cyc();

    // FIPS-197 C.1 keystream with zero data
    clear_mon();
    configure(NON, 16'd1);
    din[0] = '0;
    stream(1, 1, 0);
    repeat (2) cyc();
    check("fips_data", dout[0], FIPS);
    check("fips_last", 128'(dlast[0]), 128'd1);
    check("fips_done", 128'(ndone), 128'd1);
    check("fips_idle", 128'(ctl(0)), 128'h40);
    check("fips_nctr", 128'(blk_log.size()), 128'd1);
    check("fips_ctr0", blk_log[0], NON);

    // round trip of the FIPS ciphertext, counter order
    clear_mon();
    configure(NON, 16'd2);
    din[0] = FIPS;
    din[1] = '0;
    stream(2, 2, 0);
    repeat (2) cyc();
    check("rt_data0", dout[0], '0);
    check("rt_last", 128'({dlast[0], dlast[1]}), 128'd1);
    check("rt_nctr", 128'(blk_log.size()), 128'd2);
    check("rt_ctr0", blk_log[0], NON);
    check("rt_ctr1", blk_log[1], NON1);
    check("rt_done", 128'(ndone), 128'd1);

    // backpressure
    clear_mon();
    configure(NON, 16'd4);
    din[0] = FIPS;
    din[1] = 128'd1;
    din[2] = 128'd2;
    din[3] = 128'd3;
    stream(4, 4, 20);
    repeat (2) cyc();
    dup = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (dout[i] === dout[j]) dup++;
    for (int i = 0; i < 4; i++) keep[i] = dout[i];
    check("bp_data0", dout[0], '0);
    check("bp_last", 128'({dlast[0], dlast[1], dlast[2], dlast[3]}), 128'd1);
    check("bp_distinct", 128'(dup), 128'd0);
    check("bp_done", 128'(ndone), 128'd1);
    check("bp_ctr3", blk_log[3], NON3);

    // zero-length session
    clear_mon();
    configure(NON, 16'd0);
    @(negedge clk);
    check("z_done", 128'(dn[0]), 128'd1);
    check("z_busy", 128'(by[0]), 128'd0);
    zov = 1'b0;
    for (int t = 0; t < 6; t++) begin
      cyc();
      if (ov[0]) zov = 1'b1;
    end
    check("z_ov", 128'(zov), 128'd0);
    check("z_ndone", 128'(ndone), 128'd1);

    // reset in the middle of a 4-block session
    clear_mon();
    configure(NON, 16'd4);
    din[0] = FIPS;
    din[1] = 128'd5;
    din[2] = 128'd6;
    din[3] = 128'd7;
    stream(4, 1, 0);
    reset = 1'b1;
    cyc();
    @(negedge clk);
    check("mr_ctl", 128'(ctl(0)), 128'h40);
    check("mr_data", od[0], '0);
    reset = 1'b0;
    cyc();
    check("mr_nodone", 128'(ndone), 128'd0);

    // fresh session decrypts the backpressure ciphertext
    clear_mon();
    configure(NON, 16'd4);
    for (int i = 0; i < 4; i++) din[i] = keep[i];
    stream(4, 4, 0);
    repeat (2) cyc();
    check("nr_data0", dout[0], FIPS);
    check("nr_data1", dout[1], 128'd1);
    check("nr_data2", dout[2], 128'd2);
    check("nr_data3", dout[3], 128'd3);
    check("nr_done", 128'(ndone), 128'd1);

    // 8-bit counter wrap from ff
    sel = 1'b1;
    cyc();
    clear_mon();
    configure(NON, 16'd2);
`ifdef CTR_WRAP_CHECK_EN
    in_valid = 1'b1;
    in_data = '0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && nerr == 0; t++) cyc();
    check("w_err_seen", 128'(nerr), 128'd1);
    check("w_abort_ctl", 128'(ctl(1)), 128'h40);
    repeat (5) cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("w_nerr", 128'(nerr), 128'd1);
    check("w_nodone", 128'(ndone), 128'd0);
    check("w_idle", 128'(ctl(1)), 128'h40);
`else
    din[0] = '0;
    din[1] = '0;
    stream(2, 2, 0);
    repeat (2) cyc();
    check("w_nctr", 128'(blk_log.size()), 128'd2);
    check("w_ctr0", blk_log[0], NON);
    check("w_ctr1", blk_log[1], NONW);
    check("w_last", 128'(dlast[1]), 128'd1);
    check("w_done", 128'(ndone), 128'd1);
    check("w_noerr", 128'(nerr), 128'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
